ca_row_generator: RTL and testbench

Upstream stage of the cellular-automaton frame buffer path. It produces one full frame of a 1-D elementary cellular automaton: row 0 is a single live seed cell, and each following row is derived from the previous one by an 8-bit rule. Pixels stream out in raster order over a valid/ready write interface, which the SRAM frame buffer consumes and stores.

---
 rtl/ca_pkg.sv | 39 +++
 rtl/ca_row_buffer.sv | 87 ++++++++
 rtl/ca_row_generator.sv | 132 +++++++++++++
 tb/tb_ca_row_generator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared types, colours and the rule lookup for the cellular-automaton row generator.
// Pixel component widths come from R_SIZE/G_SIZE/B_SIZE. When a build does not
// provide them, each component defaults to 4 bits.
`ifndef R_SIZE
`define R_SIZE 4
`endif
`ifndef G_SIZE
`define G_SIZE 4
`endif
`ifndef B_SIZE
`define B_SIZE 4
`endif

package ca_pkg;

    localparam int CA_H_DISPLAY = 640;
    localparam int CA_V_DISPLAY = 480;

    localparam int RGB_W = `R_SIZE + `G_SIZE + `B_SIZE;

    localparam logic [RGB_W-1:0] FG_COLOR = '1;
    localparam logic [RGB_W-1:0] BG_COLOR = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT    = 2'd1,
        GEN     = 2'd2,
        ROW_END = 2'd3
    } ca_state_e;

    // Wolfram rule lookup. The left neighbour is the MSB of the index.
    function automatic logic ca_next_cell(input logic [7:0] rule,
                                          input logic       left,
                                          input logic       centre,
                                          input logic       right);
        return rule[{left, centre, right}];
    endfunction

endpackage

// File: rtl/ca_row_buffer.sv
// Ping-pong row storage for the automaton: one bank holds the row being displayed
// (cur), and the other bank collects the next row (nxt). Swapping only flips the
// bank select. The neighbourhood of column x_i is presented combinationally.
// Macro CA_WRAP_EN: when it is defined, the edge neighbours wrap around the row.
// When it is undefined, the edge neighbours read as 0.
module ca_row_buffer
    import ca_pkg::*;
#(
    parameter int H  = CA_H_DISPLAY,
    parameter int XW = $clog2(H)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic          wr_bit_i,
    input  logic          swap_i,
    input  logic [XW-1:0] x_i,
    output logic          cur_l_o,
    output logic          cur_c_o,
    output logic          cur_r_o
);

    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_LAST = XW'(H - 1);

    logic [H-1:0] bank_a_q, bank_a_d;
    logic [H-1:0] bank_b_q, bank_b_d;
    logic         sel_q, sel_d;
    logic [H-1:0] cur_row;
    logic         x_first, x_last;

    // sel_q = 0 : bank A is cur and bank B is nxt; sel_q = 1 swaps the roles.
    assign cur_row = sel_q ? bank_b_q : bank_a_q;
    assign x_first = (x_i == '0);
    assign x_last  = (x_i == X_LAST);

    // Next-state logic: clear and seed, write one bit into nxt, or swap banks.
    always_comb begin
        bank_a_d = bank_a_q;
        bank_b_d = bank_b_q;
        sel_d    = sel_q;
        if (clr_i) begin
            bank_a_d        = '0;
            bank_b_d        = '0;
            bank_a_d[H/2]   = 1'b1;
            sel_d           = 1'b0;
        end else begin
            if (wr_en_i) begin
                if (sel_q) begin
                    bank_a_d[x_i] = wr_bit_i;
                end else begin
                    bank_b_d[x_i] = wr_bit_i;
                end
            end
            if (swap_i) begin
                sel_d = ~sel_q;
            end
        end
    end

    // Bank and select registers; reset clears both rows.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bank_a_q <= '0;
            bank_b_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            bank_a_q <= bank_a_d;
            bank_b_q <= bank_b_d;
            sel_q    <= sel_d;
        end
    end

    // Neighbourhood of the current column with the selected edge handling.
    always_comb begin
        cur_c_o = cur_row[x_i];
`ifdef CA_WRAP_EN
        cur_l_o = x_first ? cur_row[H-1] : cur_row[x_i - X_ONE];
        cur_r_o = x_last  ? cur_row[0]   : cur_row[x_i + X_ONE];
`else
        cur_l_o = x_first ? 1'b0 : cur_row[x_i - X_ONE];
        cur_r_o = x_last  ? 1'b0 : cur_row[x_i + X_ONE];
`endif
    end

endmodule

// File: rtl/ca_row_generator.sv
// Generates one frame of a 1-D elementary cellular automaton. Row 0 is a single
// seed cell. Pixels stream out in raster order over a valid/ready write port.
// Macro CA_WRAP_EN (handled in ca_row_buffer) selects toroidal edge neighbours.
//
// state   | meaning
// IDLE    | waiting for ca_start (a start in the done cycle is ignored)
// INIT    | clear banks, seed the centre cell, zero x/y
// GEN     | offer pixel (x,y); on accept store next-row bit and advance x
// ROW_END | bubble cycle: swap banks, next row or finish with ca_done
module ca_row_generator
    import ca_pkg::*;
#(
    parameter  int H_DISPLAY = CA_H_DISPLAY,
    parameter  int V_DISPLAY = CA_V_DISPLAY,
    localparam int XW        = $clog2(H_DISPLAY),
    localparam int YW        = $clog2(V_DISPLAY)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       ca_rule,
    input  logic             ca_start,
    output logic             ca_busy,
    output logic             ca_done,
    output logic             ca_wr_valid,
    input  logic             ca_wr_ready,
    output logic [XW-1:0]    ca_wr_x,
    output logic [YW-1:0]    ca_wr_y,
    output logic [RGB_W-1:0] ca_wr_rgb
);

    localparam logic [XW-1:0] X_LAST = XW'(H_DISPLAY - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_DISPLAY - 1);

    ca_state_e     state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    rule_q, rule_d;
    logic          done_q, done_d;

    logic          buf_clr, buf_wr, buf_swap;
    logic          cur_l, cur_c, cur_r;

    ca_row_buffer #(
        .H  (H_DISPLAY),
        .XW (XW)
    ) u_row_buffer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clr_i    (buf_clr),
        .wr_en_i  (buf_wr),
        .wr_bit_i (ca_next_cell(rule_q, cur_l, cur_c, cur_r)),
        .swap_i   (buf_swap),
        .x_i      (x_q),
        .cur_l_o  (cur_l),
        .cur_c_o  (cur_c),
        .cur_r_o  (cur_r)
    );

    // Next-state, counter and row-buffer control decode.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rule_d   = rule_q;
        done_d   = 1'b0;
        buf_clr  = 1'b0;
        buf_wr   = 1'b0;
        buf_swap = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done_q high means the previous frame is still closing out.
                if (ca_start && !done_q) begin
                    rule_d  = ca_rule;
                    state_d = INIT;
                end
            end
            INIT: begin
                buf_clr = 1'b1;
                x_d     = '0;
                y_d     = '0;
                state_d = GEN;
            end
            GEN: begin
                if (ca_wr_ready) begin
                    buf_wr = 1'b1;
                    if (x_q == X_LAST) begin
                        state_d = ROW_END;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ROW_END: begin
                buf_swap = 1'b1;
                x_d      = '0;
                if (y_q == Y_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    y_d     = y_q + YW'(1);
                    state_d = GEN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched rule and done pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rule_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rule_q  <= rule_d;
            done_q  <= done_d;
        end
    end

    assign ca_busy     = (state_q != IDLE);
    assign ca_done     = done_q;
    assign ca_wr_valid = (state_q == GEN);
    assign ca_wr_x     = x_q;
    assign ca_wr_y     = y_q;
    assign ca_wr_rgb   = (ca_wr_valid && cur_c) ? FG_COLOR : BG_COLOR;

endmodule

// File: tb/tb_ca_row_generator.sv
// Self-checking bench for ca_row_generator on a reduced 16x12 frame.
// The reference frame is computed directly from the automaton rules.
module tb_ca_row_generator;
    import ca_pkg::*;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [7:0]       ca_rule = '0;
    logic             ca_start = 1'b0;
    logic             ca_busy, ca_done, ca_wr_valid;
    logic             ca_wr_ready = 1'b0;
    logic [XW-1:0]    ca_wr_x;
    logic [YW-1:0]    ca_wr_y;
    logic [RGB_W-1:0] ca_wr_rgb;

    int total = 0;
    int bad   = 0;
    bit wrap  = 1'b0;
    bit exp_px [V][H];

    always #5 sys_clk = ~sys_clk;

    ca_row_generator #(
        .H_DISPLAY (H),
        .V_DISPLAY (V)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .ca_rule     (ca_rule),
        .ca_start    (ca_start),
        .ca_busy     (ca_busy),
        .ca_done     (ca_done),
        .ca_wr_valid (ca_wr_valid),
        .ca_wr_ready (ca_wr_ready),
        .ca_wr_x     (ca_wr_x),
        .ca_wr_y     (ca_wr_y),
        .ca_wr_rgb   (ca_wr_rgb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input logic [7:0] rule);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                exp_px[r][c] = 1'b0;
        exp_px[0][H/2] = 1'b1;
        for (int r = 1; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                int l, m, rr, idx;
                m = exp_px[r-1][c];
                if (c == 0) l = wrap ? int'(exp_px[r-1][H-1]) : 0;
                else        l = exp_px[r-1][c-1];
                if (c == H-1) rr = wrap ? int'(exp_px[r-1][0]) : 0;
                else          rr = exp_px[r-1][c+1];
                idx = 4*l + 2*m + rr;
                exp_px[r][c] = ((int'(rule) >> idx) & 1) != 0;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] rule, input int ready_pct, input bit do_stall,
                             input bit inject, input int rst_row);
        int ex_x = 0, ex_y = 0, accepts = 0, cyc = 2, stall_left = 0;
        bit prev_hold = 0, injected = 0, stall_done = 0, finished = 0, aborted = 0;
        logic [XW-1:0] hx = '0;
        logic [YW-1:0] hy = '0;
        logic [RGB_W-1:0] hrgb = '0;
        logic rdy;
        build_model(rule);
        @(negedge sys_clk);
        ca_rule  = rule;
        ca_start = 1'b1;
        @(negedge sys_clk);
        ca_start = 1'b0;
        chk("start_busy", ca_busy, 1);
        chk("start_valid_low", ca_wr_valid, 0);
        @(negedge sys_clk);
        chk("first_valid", ca_wr_valid, 1);
        ca_rule = ~rule;
        for (int n = 0; n < 30*H*V + 200 && !finished && !aborted; n++) begin
            if (rst_row >= 0 && ex_y == rst_row && ex_x == 3) begin
                sys_rst = 1'b1;
                #1;
                chk("rst_valid", ca_wr_valid, 0);
                chk("rst_busy", ca_busy, 0);
                chk("rst_done", ca_done, 0);
                chk("rst_x", ca_wr_x, 0);
                chk("rst_y", ca_wr_y, 0);
                chk("rst_rgb", ca_wr_rgb, BG_COLOR);
                @(negedge sys_clk);
                sys_rst     = 1'b0;
                ca_wr_ready = 1'b0;
                aborted     = 1;
            end else if (ca_done) begin
                finished = 1;
                chk("done_accepts", accepts, H*V);
                chk("done_busy_low", ca_busy, 0);
                if (ready_pct == 0 && !do_stall) chk("frame_cycles", cyc, H*V + V + 2);
                ca_start = 1'b1;
                ca_rule  = rule ^ 8'hff;
                @(negedge sys_clk);
                ca_start = 1'b0;
                chk("done_single", ca_done, 0);
                chk("start_at_done_ignored", ca_busy, 0);
                @(negedge sys_clk);
                chk("idle_valid", ca_wr_valid, 0);
                chk("idle_busy", ca_busy, 0);
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", ca_wr_valid, 1);
                    chk("hold_x", ca_wr_x, hx);
                    chk("hold_y", ca_wr_y, hy);
                    chk("hold_rgb", ca_wr_rgb, hrgb);
                end
                chk("busy_cont", ca_busy, 1);
                ca_start = 1'b0;
                if (inject && !injected && accepts >= H*V/2) begin
                    ca_start = 1'b1;
                    ca_rule  = rule ^ 8'h5a;
                    injected = 1;
                end
                if (do_stall && !stall_done && ca_wr_valid && ex_y == 3 && ex_x == 5) begin
                    stall_left = 5;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (ready_pct == 0) begin
                    rdy = 1'b1;
                end else begin
                    rdy = ($urandom_range(99) >= ready_pct);
                end
                ca_wr_ready = rdy;
                if (ca_wr_valid && rdy) begin
                    chk("pix_x", ca_wr_x, ex_x);
                    chk("pix_y", ca_wr_y, ex_y);
                    chk("pix_rgb", ca_wr_rgb, exp_px[ex_y][ex_x] ? FG_COLOR : BG_COLOR);
                    accepts++;
                    if (ex_x == H-1) begin
                        ex_x = 0;
                        ex_y++;
                    end else begin
                        ex_x++;
                    end
                end
                prev_hold = ca_wr_valid && !rdy;
                hx   = ca_wr_x;
                hy   = ca_wr_y;
                hrgb = ca_wr_rgb;
                @(negedge sys_clk);
                cyc++;
            end
        end
        chk("frame_ended", finished | aborted, 1);
        ca_start    = 1'b0;
        ca_wr_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] rnd;
`ifdef CA_WRAP_EN
        wrap = 1'b1;
`endif
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("reset_valid", ca_wr_valid, 0);
        chk("reset_busy", ca_busy, 0);
        chk("reset_done", ca_done, 0);
        chk("reset_x", ca_wr_x, 0);
        chk("reset_y", ca_wr_y, 0);
        chk("reset_rgb", ca_wr_rgb, BG_COLOR);
        sys_rst = 1'b0;

        run_frame(8'd0,   0,  0, 0, -1);
        run_frame(8'd90,  0,  0, 0, -1);
        run_frame(8'd170, 0,  0, 0, -1);
        run_frame(8'd30,  30, 1, 0, -1);
        run_frame(8'd110, 40, 0, 1, -1);
        run_frame(8'd150, 0,  0, 0, 10);
        rnd = 8'($urandom_range(255));
        run_frame(rnd,    0,  0, 0, -1);
        rnd = 8'($urandom_range(255));
        run_frame(rnd,    25, 0, 1, -1);
        rnd = 8'($urandom_range(255));
        run_frame(rnd,    50, 1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
